// File: rtl/vga_field_overlay_if.sv
// vga_field_overlay_if: pixel stream in, font ROM port, overlay pixel out
//  pix_x/pix_y/pix_valid : current pixel from the sync counter
//  rom_addr/rom_data     : synchronous font ROM, data one clock after address
//  text_on/text_rgb      : overlay pixel towards the RGB mux
interface vga_field_overlay_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [2:0]  text_rgb;
  modport master (output pix_x, pix_y, pix_valid, rom_data, input rom_addr, text_on, text_rgb);
  modport slave  (input pix_x, pix_y, pix_valid, rom_data, output rom_addr, text_on, text_rgb);
endinterface

// File: rtl/vga_field_overlay.sv
// vga_field_overlay: BCD field text overlay with ':' separators, blinking cursor and latched alarm cell
//  clk_i, rst_i           : pixel clock, synchronous active-high reset
//  pix                    : pixel stream, font ROM port and overlay output (vga_field_overlay_if)
//  digits_i               : NUM_FIELDS x {tens,units} BCD
//  cursor_en, cursor_sel  : cursor enable and field under edit
//  alarm_i, alarm_ack     : alarm request level and latch clear pulse
module vga_field_overlay #(
  parameter int NUM_FIELDS     = 9,
  parameter int FIELDS_PER_ROW = 3,
  parameter int ROW_BASE       = 1,
  parameter int COL_BASE       = 2,
  parameter int ALARM_ROW      = 4,
  parameter int ALARM_COL      = 8,
  parameter int BLINK_DIV      = 50_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  vga_field_overlay_if.slave      pix,
  input  logic [8*NUM_FIELDS-1:0] digits_i,
  input  logic                    cursor_en,
  input  logic [3:0]              cursor_sel,
  input  logic                    alarm_i,
  input  logic                    alarm_ack
);
  typedef enum logic [1:0] {K_NONE, K_DIGIT, K_COLON, K_ALARM} kind_t;
  localparam int CW = $clog2(BLINK_DIV);
  logic [4:0] col;
  logic [3:0] row;
  kind_t kind_d, kind1, kind2;
  logic [3:0] fld_d, dig_d;
  logic [6:0] char_d;
  logic cur_d, cur1, cur2;
  logic [2:0] bit1, bit2;
  logic [CW-1:0] cnt;
  logic blink, alarm_q, alarm_lat;
  logic on_n, font_bit;
  logic [2:0] rgb_n;
  logic unused_bits;
  assign col = pix.pix_x[9:5];
  assign row = pix.pix_y[9:6];
  assign unused_bits = ^{pix.pix_x[1:0], pix.pix_y[1:0]};
  // Field cells are decoded after the alarm cell so they win on overlap.
  always_comb begin
    kind_d = (int'(row) == ALARM_ROW && int'(col) == ALARM_COL) ? K_ALARM : K_NONE;
    fld_d = '0;
    dig_d = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      if (int'(row) == ROW_BASE + i / FIELDS_PER_ROW) begin
        if (int'(col) == COL_BASE + 3 * (i % FIELDS_PER_ROW)) begin
          kind_d = K_DIGIT;
          fld_d = 4'(i);
          dig_d = digits_i[8*i+4 +: 4];
        end
        if (int'(col) == COL_BASE + 3 * (i % FIELDS_PER_ROW) + 1) begin
          kind_d = K_DIGIT;
          fld_d = 4'(i);
          dig_d = digits_i[8*i +: 4];
        end
        if (int'(col) == COL_BASE + 3 * (i % FIELDS_PER_ROW) + 2 &&
            i % FIELDS_PER_ROW != FIELDS_PER_ROW - 1 && i != NUM_FIELDS - 1)
          kind_d = K_COLON;
      end
    if (!pix.pix_valid) kind_d = K_NONE;
    char_d = kind_d == K_COLON ? 7'h3A : dig_d > 4'd9 ? 7'h3F : {3'b011, dig_d};
    cur_d = cursor_en && kind_d == K_DIGIT && fld_d == cursor_sel;
  end
  // Glyph bit 0 is the leftmost pixel, which the ROM puts in bit 7.
  assign font_bit = pix.rom_data[3'd7 - bit2];
  always_comb begin
    on_n = kind2 != K_NONE;
    rgb_n = kind2 == K_ALARM ? (alarm_lat ? (blink ? 3'b010 : 3'b100) : 3'b110) :
            kind2 == K_NONE  ? 3'b000 :
            font_bit         ? 3'b100 :
            (cur2 && blink)  ? 3'b101 : 3'b000;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pix.rom_addr <= '0;
      pix.text_on <= 1'b0;
      pix.text_rgb <= '0;
      kind1 <= K_NONE;
      kind2 <= K_NONE;
      cur1 <= 1'b0;
      cur2 <= 1'b0;
      bit1 <= '0;
      bit2 <= '0;
      cnt <= '0;
      blink <= 1'b0;
      alarm_q <= 1'b0;
      alarm_lat <= 1'b0;
    end else begin
      if (kind_d == K_DIGIT || kind_d == K_COLON) pix.rom_addr <= {char_d, pix.pix_y[5:2]};
      kind1 <= kind_d;
      cur1 <= cur_d;
      bit1 <= pix.pix_x[4:2];
      kind2 <= kind1;
      cur2 <= cur1;
      bit2 <= bit1;
      pix.text_on <= on_n;
      pix.text_rgb <= rgb_n;
      cnt <= cnt == CW'(BLINK_DIV - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(BLINK_DIV - 1)) blink <= ~blink;
      alarm_q <= alarm_i;
      // A new rising edge beats a simultaneous acknowledge.
      alarm_lat <= (alarm_i && !alarm_q) || (alarm_lat && !alarm_ack);
    end
endmodule

// File: tb/tb_vga_field_overlay.sv
// tb_vga_field_overlay: randomized scoreboard bench for vga_field_overlay
module tb_vga_field_overlay;
  localparam int NF = 9, FPR = 3, RB = 1, CB = 2, AR = 4, AC = 8, BD = 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [8*NF-1:0] digits_i = '0;
  logic cursor_en = 1'b0;
  logic [3:0] cursor_sel = '0;
  logic alarm_i = 1'b0;
  logic alarm_ack = 1'b0;
  vga_field_overlay_if bus();
  vga_field_overlay #(.NUM_FIELDS(NF), .FIELDS_PER_ROW(FPR), .ROW_BASE(RB), .COL_BASE(CB),
                      .ALARM_ROW(AR), .ALARM_COL(AC), .BLINK_DIV(BD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pix(bus.slave), .digits_i(digits_i), .cursor_en(cursor_en),
    .cursor_sel(cursor_sel), .alarm_i(alarm_i), .alarm_ack(alarm_ack));
  always #5 clk_i = ~clk_i;
  function automatic logic [7:0] font(input logic [10:0] a);
    return 8'((a * 11'd37) ^ {3'b000, a[10:3]} ^ 11'h5A);
  endfunction
  always @(posedge clk_i) bus.rom_data <= font(bus.rom_addr);
  int edge_n = 0;
  always @(posedge clk_i) edge_n <= edge_n + 1;
  typedef struct {int k; logic [10:0] addr;} a_rec_t;
  typedef struct {int k; logic [3:0] v;} o_rec_t;
  a_rec_t aq[$];
  o_rec_t oq[$];
  int checks = 0, errors = 0;
  logic n_rst = 1'b1, n_cen = 1'b0, n_ai = 1'b0, n_ack = 1'b0;
  logic [8*NF-1:0] n_dig = '0;
  logic [3:0] n_csel = '0;
  logic [10:0] m_addr = '0;
  logic m_latch = 1'b0, m_prev = 1'b0, prev_rst = 1'b1;
  int f_edge = 0;
  task automatic drive(input int x, input int y, input logic v);
    int k, row, col, kind, fld, d, cf;
    logic [7:0] fr;
    logic [6:0] ch;
    logic [2:0] rgb;
    logic bl, fb;
    @(negedge clk_i);
    rst_i = n_rst;
    bus.pix_x = 10'(x);
    bus.pix_y = 10'(y);
    bus.pix_valid = v;
    digits_i = n_dig;
    cursor_en = n_cen;
    cursor_sel = n_csel;
    alarm_i = n_ai;
    alarm_ack = n_ack;
    k = edge_n + 1;
    if (n_rst) begin
      if (!prev_rst) foreach (oq[j]) oq[j].v = 4'd0;
      prev_rst = 1'b1;
      m_addr = '0;
      m_latch = 1'b0;
      m_prev = 1'b0;
      aq.push_back('{k, 11'd0});
      oq.push_back('{k, 4'd0});
      return;
    end
    if (prev_rst) f_edge = k;
    prev_rst = 1'b0;
    m_latch = (n_ai && !m_prev) ? 1'b1 : n_ack ? 1'b0 : m_latch;
    m_prev = n_ai;
    row = y / 64;
    col = x / 32;
    kind = (row == AR && col == AC) ? 3 : 0;
    fld = 0;
    d = 0;
    for (int i = 0; i < NF; i++) begin
      cf = CB + 3 * (i % FPR);
      if (row == RB + i / FPR) begin
        if (col == cf) begin kind = 1; fld = i; d = int'(n_dig[8*i+4 +: 4]); end
        if (col == cf + 1) begin kind = 1; fld = i; d = int'(n_dig[8*i +: 4]); end
        if (col == cf + 2 && i % FPR != FPR - 1 && i != NF - 1) kind = 2;
      end
    end
    if (!v) kind = 0;
    if (kind == 1 || kind == 2) begin
      ch = kind == 2 ? 7'h3A : d > 9 ? 7'h3F : 7'(48 + d);
      m_addr = {ch, 4'((y % 64) / 4)};
    end
    aq.push_back('{k, m_addr});
    bl = ((k + 2 - f_edge) / BD) % 2 == 1;
    fr = font(m_addr);
    fb = fr[7 - (x % 32) / 4];
    if (kind == 0) rgb = 3'b000;
    else if (kind == 3) rgb = m_latch ? (bl ? 3'b010 : 3'b100) : 3'b110;
    else if (fb) rgb = 3'b100;
    else if (kind == 1 && n_cen && fld == int'(n_csel)) rgb = bl ? 3'b101 : 3'b000;
    else rgb = 3'b000;
    oq.push_back('{k, {kind != 0, rgb}});
  endtask
  task automatic alarm_evt(input logic ai, input logic ack);
    drive(0, 0, 1'b0);
    n_ai = ai;
    n_ack = ack;
    drive(0, 0, 1'b0);
    n_ack = 1'b0;
  endtask
  initial forever begin
    @(posedge clk_i);
    #1;
    if (aq.size() > 0 && aq[0].k == edge_n) begin
      checks++;
      if (bus.rom_addr !== aq[0].addr) begin
        errors++;
        $display("FAIL rom_addr edge %0d got %h want %h", edge_n, bus.rom_addr, aq[0].addr);
      end
      void'(aq.pop_front());
    end
    if (oq.size() > 0 && oq[0].k + 2 == edge_n) begin
      checks++;
      if ({bus.text_on, bus.text_rgb} !== oq[0].v) begin
        errors++;
        $display("FAIL pixel edge %0d got on=%b rgb=%b want on=%b rgb=%b", edge_n,
                 bus.text_on, bus.text_rgb, oq[0].v[3], oq[0].v[2:0]);
      end
      void'(oq.pop_front());
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    drive(64, 64, 1'b1);
    drive(64, 64, 1'b1);
    n_rst = 1'b0;
    n_dig[7:0] = 8'h42;
    drive(64, 64, 1'b1);
    for (int j = 0; j < 8; j++) drive(64 + 4 * j, 64 + 4 * j, 1'b1);
    n_dig[7:0] = 8'hA5;
    drive(64, 64, 1'b1);
    drive(320, 64, 1'b1);
    drive(96, 64, 1'b1);
    drive(128, 64, 1'b1);
    drive(64, 64, 1'b0);
    n_cen = 1'b1;
    n_csel = 4'd1;
    for (int j = 0; j < 16; j++) drive(160 + 4 * (j % 8), 64 + 4 * (j / 8), 1'b1);
    n_csel = 4'd9;
    for (int j = 0; j < 8; j++) drive(160 + 4 * j, 68, 1'b1);
    alarm_evt(1'b1, 1'b0);
    repeat (12) drive(256, 256, 1'b1);
    alarm_evt(1'b1, 1'b1);
    repeat (4) drive(256, 256, 1'b1);
    alarm_evt(1'b0, 1'b0);
    alarm_evt(1'b1, 1'b1);
    repeat (6) drive(256, 256, 1'b1);
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        n_rst = 1'b1;
        drive(64, 64, 1'b1);
        drive(64, 64, 1'b1);
        n_rst = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) alarm_evt(1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) n_dig = 72'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 15) == 0) begin
        n_cen = 1'($urandom);
        n_csel = 4'($urandom_range(0, 10));
      end
      drive($urandom_range(0, 12) * 32 + $urandom_range(0, 31),
            $urandom_range(0, 6) * 64 + $urandom_range(0, 63), $urandom_range(0, 9) != 0);
    end
    repeat (4) drive(0, 0, 1'b0);
    repeat (3) @(posedge clk_i);
    #2;
    checks++;
    if (aq.size() != 0 || oq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", aq.size(), oq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
